controle_partida: RTL and testbench

- Game sequencer for the chess clock. Sits between the edge detectors and the dual-timer datapath.
- Consumes one-cycle button pulses (carga_int, j1_int, j2_int, pausa_int) and the timers' time-up flags.
- Decides whose clock runs, generates the 1 Hz count tick, issues load and increment strobes, and counts moves.
- The dual timer becomes a pure datapath: it only loads, decrements on tick and adds a bonus when told.

---
 rtl/controle_partida_pkg.sv | 17 +
 rtl/controle_partida_divisor_tick.sv | 48 ++++
 rtl/controle_partida.sv | 155 +++++++++++++++
 tb/tb_controle_partida.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/controle_partida_pkg.sv
// Shared encodings for the chess-clock game sequencer: FSM states and winner codes.
package controle_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CARREGADO = 3'd1,
    VEZ_J1    = 3'd2,
    VEZ_J2    = 3'd3,
    PAUSA     = 3'd4,
    FIM       = 3'd5
  } state_t;

  localparam logic [1:0] NENHUM = 2'd0;
  localparam logic [1:0] J1     = 2'd1;
  localparam logic [1:0] J2     = 2'd2;

endpackage

// File: rtl/controle_partida_divisor_tick.sv
// Prescaler: counts enabled cycles and emits a registered one-cycle tick every CLOCK_FREQ counts.
module divisor_tick #(
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Clear wins over counting, so a turn change never produces a tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/controle_partida.sv
// Chess-clock game sequencer: decides whose timer runs, issues load/bonus strobes, counts moves.
module controle_partida
  import controle_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int JOG_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             carga_int,
  input  logic             j1_int,
  input  logic             j2_int,
  input  logic             pausa_int,
  input  logic [6:0]       chaves,
  input  logic             j1_fim,
  input  logic             j2_fim,
  output logic             carga_out,
  output logic [6:0]       valor_carga,
  output logic             en_j1,
  output logic             en_j2,
  output logic             tick,
  output logic             bonus_j1,
  output logic             bonus_j2,
  output logic [JOG_W-1:0] jogadas,
  output logic [2:0]       estado,
  output logic [1:0]       vencedor
);

  function automatic logic [JOG_W-1:0] sat_inc(input logic [JOG_W-1:0] v);
    return (&v) ? v : v + JOG_W'(1);
  endfunction

  state_t           state_q, state_d, turno_q, turno_d;
  logic [6:0]       valor_q, valor_d;
  logic [JOG_W-1:0] jog_q, jog_d;
  logic [1:0]       venc_q, venc_d;
  logic             carga_q, carga_d;
  logic             bonus1_q, bonus1_d, bonus2_q, bonus2_d;
  logic             en1_q, en2_q;
  logic             clr_s, en_s;

  // Next-state and strobe decode; an accepted load overrides everything else.
  always_comb begin
    state_d  = state_q;
    turno_d  = turno_q;
    valor_d  = valor_q;
    jog_d    = jog_q;
    venc_d   = venc_q;
    carga_d  = 1'b0;
    bonus1_d = 1'b0;
    bonus2_d = 1'b0;
    clr_s    = 1'b0;
    if (carga_int && (chaves != 7'd0)) begin
      state_d = CARREGADO;
      valor_d = chaves;
      carga_d = 1'b1;
      jog_d   = '0;
      venc_d  = NENHUM;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        CARREGADO: begin
          if (j1_int)      state_d = VEZ_J2;
          else if (j2_int) state_d = VEZ_J1;
          else             state_d = state_q;
        end
        VEZ_J1: begin
          if (j1_fim) begin
            state_d = FIM;
            venc_d  = J2;
          end else if (j1_int) begin
            state_d  = VEZ_J2;
            bonus1_d = 1'b1;
            jog_d    = sat_inc(jog_q);
            clr_s    = 1'b1;
          end else if (pausa_int) begin
            state_d = PAUSA;
            turno_d = VEZ_J1;
          end else begin
            state_d = state_q;
          end
        end
        VEZ_J2: begin
          if (j2_fim) begin
            state_d = FIM;
            venc_d  = J1;
          end else if (j2_int) begin
            state_d  = VEZ_J1;
            bonus2_d = 1'b1;
            jog_d    = sat_inc(jog_q);
            clr_s    = 1'b1;
          end else if (pausa_int) begin
            state_d = PAUSA;
            turno_d = VEZ_J2;
          end else begin
            state_d = state_q;
          end
        end
        PAUSA: begin
          if (pausa_int) state_d = turno_q;
          else           state_d = state_q;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // The prescaler only advances while a turn keeps running, so the pausing edge does not count.
  assign en_s = ((state_q == VEZ_J1) || (state_q == VEZ_J2)) && (state_d == state_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      turno_q  <= VEZ_J1;
      valor_q  <= 7'd0;
      jog_q    <= '0;
      venc_q   <= NENHUM;
      carga_q  <= 1'b0;
      bonus1_q <= 1'b0;
      bonus2_q <= 1'b0;
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      turno_q  <= turno_d;
      valor_q  <= valor_d;
      jog_q    <= jog_d;
      venc_q   <= venc_d;
      carga_q  <= carga_d;
      bonus1_q <= bonus1_d;
      bonus2_q <= bonus2_d;
      en1_q    <= (state_d == VEZ_J1);
      en2_q    <= (state_d == VEZ_J2);
    end
  end

  divisor_tick #(.CLOCK_FREQ(CLOCK_FREQ)) u_divisor (
    .clock (clock),
    .reset (reset),
    .en    (en_s),
    .clr   (clr_s),
    .tick  (tick)
  );

  assign estado      = state_q;
  assign valor_carga = valor_q;
  assign jogadas     = jog_q;
  assign vencedor    = venc_q;
  assign carga_out   = carga_q;
  assign bonus_j1    = bonus1_q;
  assign bonus_j2    = bonus2_q;
  assign en_j1       = en1_q;
  assign en_j2       = en2_q;

endmodule

// File: tb/tb_controle_partida.sv
// Directed self-checking bench for controle_partida with a 10-cycle tick period.
module tb_controle_partida;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       carga_int = 1'b0, j1_int = 1'b0, j2_int = 1'b0, pausa_int = 1'b0;
  logic [6:0] chaves = 7'd0;
  logic       j1_fim = 1'b0, j2_fim = 1'b0;
  logic       carga_out, en_j1, en_j2, tick, bonus_j1, bonus_j2;
  logic [6:0] valor_carga;
  logic [7:0] jogadas;
  logic [2:0] estado;
  logic [1:0] vencedor;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt, first, last;

  controle_partida #(.CLOCK_FREQ(10), .JOG_W(8)) dut (
    .clock(clock), .reset(reset), .carga_int(carga_int), .j1_int(j1_int),
    .j2_int(j2_int), .pausa_int(pausa_int), .chaves(chaves), .j1_fim(j1_fim),
    .j2_fim(j2_fim), .carga_out(carga_out), .valor_carga(valor_carga),
    .en_j1(en_j1), .en_j2(en_j2), .tick(tick), .bonus_j1(bonus_j1),
    .bonus_j2(bonus_j2), .jogadas(jogadas), .estado(estado), .vencedor(vencedor)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic c, input logic a, input logic b, input logic p);
    carga_int = c; j1_int = a; j2_int = b; pausa_int = p;
    cyc();
    carga_int = 1'b0; j1_int = 1'b0; j2_int = 1'b0; pausa_int = 1'b0;
  endtask

  task automatic run(input int n, output int c, output int f, output int l);
    c = 0; f = -1; l = -1;
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (tick) begin
        c++;
        if (f < 0) f = i;
        l = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) cyc();
    check("rst_estado", estado, 0);
    check("rst_outs", {carga_out, valor_carga, en_j1, en_j2, tick, bonus_j1, bonus_j2, jogadas, vencedor}, 0);
    reset = 1'b1;
    cyc();

    // first load
    chaves = 7'd5;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("ld_carga_out", carga_out, 1);
    check("ld_valor", valor_carga, 5);
    check("ld_estado", estado, 1);
    check("ld_en", {en_j1, en_j2}, 0);
    cyc();
    check("ld_carga_once", carga_out, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("carr_pausa_ign", estado, 1);

    // reload with 3, player 2 starts the game so player 1 runs
    chaves = 7'd3;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("ld3_valor", valor_carga, 3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("vj1_estado", estado, 2);
    check("vj1_en", {en_j1, en_j2}, 2'b10);
    check("vj1_jog", jogadas, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("vj1_j2_ign", estado, 2);
    check("vj1_j2_nobonus", {bonus_j1, bonus_j2, jogadas}, 0);
    run(24, cnt, first, last);
    check("vj1_ticks", cnt, 2);
    check("vj1_first", first, 9);
    check("vj1_spacing", last - first, 10);

    // player 1 ends the turn
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("turn_bonus1", bonus_j1, 1);
    check("turn_jog", jogadas, 1);
    check("turn_en", {en_j1, en_j2}, 2'b01);
    check("turn_notick", tick, 0);
    run(10, cnt, first, last);
    check("turn_first_tick", first, 10);
    check("turn_bonus_once", bonus_j1, 0);

    // back to player 1, then pause after 4 counts
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("vj2_bonus2", bonus_j2, 1);
    check("vj2_jog", jogadas, 2);
    repeat (4) cyc();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("pause_estado", estado, 4);
    check("pause_en", {en_j1, en_j2}, 0);
    carga_int = 1'b0;
    j1_int = 1'b1;
    cyc();
    j1_int = 1'b0;
    check("pause_j1_ign", {estado, jogadas}, {3'd4, 8'd2});
    run(19, cnt, first, last);
    check("pause_noticks", cnt, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume_estado", estado, 2);
    check("resume_en", en_j1, 1);
    run(10, cnt, first, last);
    check("resume_first_tick", first, 6);

    // player 2 runs out of time on the same cycle as pressing
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("to_vj2_jog", jogadas, 3);
    j2_fim = 1'b1; j2_int = 1'b1;
    cyc();
    j2_fim = 1'b0; j2_int = 1'b0;
    check("fim_estado", estado, 5);
    check("fim_venc", vencedor, 1);
    check("fim_nobonus", bonus_j2, 0);
    check("fim_jog", jogadas, 3);
    check("fim_en", {en_j1, en_j2}, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("fim_j1_ign", {estado, jogadas}, {3'd5, 8'd3});
    chaves = 7'd0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fim_zero_ld", {estado, carga_out, valor_carga}, {3'd5, 1'b0, 7'd3});
    chaves = 7'd7;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fim_ld_estado", estado, 1);
    check("fim_ld_venc", vencedor, 0);
    check("fim_ld_jog", jogadas, 0);
    check("fim_ld_valor", valor_carga, 7);

    // simultaneous presses in CARREGADO, then asynchronous reset mid-turn
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("both_estado", estado, 3);
    check("both_en", {en_j1, en_j2, bonus_j1, bonus_j2}, 4'b0100);
    repeat (3) cyc();
    #2 reset = 1'b0;
    #1;
    check("async_rst", {carga_out, valor_carga, en_j1, en_j2, tick, bonus_j1, bonus_j2, jogadas, estado, vencedor}, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // move counter saturation
    chaves = 7'd5;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      else            pulse(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("sat_jog", jogadas, 255);
    check("sat_estado", estado, 2);

    // load beats a same-cycle turn end
    chaves = 7'd2;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_estado", estado, 1);
    check("prio_bonus", bonus_j1, 0);
    check("prio_jog_valor", {jogadas, valor_carga}, {8'd0, 7'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
